// File: rtl/ram_rd_streamer.sv
// Read-side streamer for simple dual-port RAMs: issues block reads,
// tracks the fixed read latency and returns words as a valid/ready stream.
module ram_rd_streamer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
   localparam logic [ADDR_WIDTH:0] ONE = 1;

   if (RD_LATENCY < 1 || RD_LATENCY > 2 ||
       FIFO_DEPTH < RD_LATENCY + 2) begin : g_bad_cfg
      $error("ram_rd_streamer: illegal RD_LATENCY/FIFO_DEPTH");
   end

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH:0]   rem_q, rem_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  done_q, done_d;
   logic [RD_LATENCY-1:0] pipe_q;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PW-1:0]         wp_q, rp_q;
   logic [CW-1:0]         fcnt_q;
   logic [CW-1:0]         used;
   logic                  push, pop, credit;

   assign push = pipe_q[RD_LATENCY-1];
   assign pop  = out_valid && out_ready;

   // Reads outstanding plus words held; a pop this cycle frees a slot now.
   always_comb begin
      used = fcnt_q + CW'(rd_en_q);
      for (int i = 0; i < RD_LATENCY; i++) begin
         used = used + CW'(pipe_q[i]);
      end
      if (pop) used = used - CW'(1);
   end

   assign credit = used < CW'(FIFO_DEPTH);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      rd_en_d   = 1'b0;
      rd_addr_d = rd_addr_q;
      done_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (count == '0) begin
                  done_d = 1'b1;
               end else begin
                  rd_en_d   = 1'b1;
                  rd_addr_d = start_addr;
                  addr_d    = start_addr + 1'b1;
                  rem_d     = count - 1'b1;
                  state_d   = (count == ONE) ? DRAIN : READ;
               end
            end
         end
         READ: begin
            if (rem_q != '0 && credit) begin
               rd_en_d   = 1'b1;
               rd_addr_d = addr_q;
               addr_d    = addr_q + 1'b1;
               rem_d     = rem_q - 1'b1;
               if (rem_q == ONE) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (!rd_en_q && pipe_q == '0 &&
                (fcnt_q == '0 || (fcnt_q == CW'(1) && pop))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         rd_en_q   <= 1'b0;
         rd_addr_q <= '0;
         done_q    <= 1'b0;
         pipe_q    <= '0;
         wp_q      <= '0;
         rp_q      <= '0;
         fcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         rd_en_q   <= rd_en_d;
         rd_addr_q <= rd_addr_d;
         done_q    <= done_d;
         pipe_q    <= (pipe_q << 1) | RD_LATENCY'(rd_en_q);
         if (push) begin
            wp_q <= (wp_q == PW'(FIFO_DEPTH - 1)) ? '0 : wp_q + 1'b1;
         end
         if (pop) begin
            rp_q <= (rp_q == PW'(FIFO_DEPTH - 1)) ? '0 : rp_q + 1'b1;
         end
         fcnt_q <= fcnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= ram_rd_data;
   end

   assign busy        = state_q != IDLE;
   assign done        = done_q;
   assign ram_rd_en   = rd_en_q;
   assign ram_rd_addr = rd_addr_q;
   assign out_valid   = fcnt_q != '0;
   assign out_data    = out_valid ? mem_q[rp_q] : '0;

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Bench for ram_rd_streamer: two instances (read latency 1 and 2)
// driven together and checked against a word-order reference model.
module tb_ram_rd_streamer;

   logic       clk;
   logic       rst;
   logic       start;
   logic [5:0] start_addr;
   logic [6:0] count;
   logic       out_ready;

   logic       busy_w    [2];
   logic       done_w    [2];
   logic       rd_en_w   [2];
   logic [5:0] rd_addr_w [2];
   logic [7:0] rd_data_w [2];
   logic       ovalid_w  [2];
   logic [7:0] odata_w   [2];

   int total = 0;
   int bad   = 0;

   ram_rd_streamer #(
      .DATA_WIDTH(8), .ADDR_WIDTH(6), .RD_LATENCY(1), .FIFO_DEPTH(4)
   ) u_l1 (
      .clk(clk), .rst(rst), .start(start),
      .start_addr(start_addr), .count(count),
      .busy(busy_w[0]), .done(done_w[0]),
      .ram_rd_en(rd_en_w[0]), .ram_rd_addr(rd_addr_w[0]),
      .ram_rd_data(rd_data_w[0]),
      .out_valid(ovalid_w[0]), .out_ready(out_ready),
      .out_data(odata_w[0])
   );

   ram_rd_streamer #(
      .DATA_WIDTH(8), .ADDR_WIDTH(6), .RD_LATENCY(2), .FIFO_DEPTH(4)
   ) u_l2 (
      .clk(clk), .rst(rst), .start(start),
      .start_addr(start_addr), .count(count),
      .busy(busy_w[1]), .done(done_w[1]),
      .ram_rd_en(rd_en_w[1]), .ram_rd_addr(rd_addr_w[1]),
      .ram_rd_data(rd_data_w[1]),
      .out_valid(ovalid_w[1]), .out_ready(out_ready),
      .out_data(odata_w[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] ram_word(input logic [5:0] a);
      return 8'((3 * int'(a)) % 256);
   endfunction

   function automatic logic [31:0] exp_word(input int a);
      return 32'((3 * (a % 64)) % 256);
   endfunction

   // RAM models: one unregistered read, one with a registered read stage
   logic [7:0] r1_q, r2a_q, r2b_q;
   always @(posedge clk) begin
      if (rd_en_w[0]) r1_q <= ram_word(rd_addr_w[0]);
      if (rd_en_w[1]) r2a_q <= ram_word(rd_addr_w[1]);
      r2b_q <= r2a_q;
   end
   assign rd_data_w[0] = r1_q;
   assign rd_data_w[1] = r2b_q;

   task automatic chk(input string tag, input int d,
                      input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s lat=%0d obs=%0d exp=%0d", tag, d + 1, obs, exp);
      end
   endtask

   task automatic chk_idle(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_busy"}, d, 32'(busy_w[d]), 0);
         chk({tag, "_done"}, d, 32'(done_w[d]), 0);
         chk({tag, "_rden"}, d, 32'(rd_en_w[d]), 0);
         chk({tag, "_valid"}, d, 32'(ovalid_w[d]), 0);
      end
   endtask

   // mode 0: ready high; 1: random ready; 2: ready low for hold cycles
   task automatic run(input int sa, input int cnt, input int mode,
                      input int hold, input bit poke);
      int issued [2];
      int deliv  [2];
      int firstv [2];
      int lastx  [2];
      int dones  [2];
      bit pheld  [2];
      logic [7:0] pdat [2];
      bit rdy;
      int k;
      int tail;
      issued = '{0, 0};
      deliv  = '{0, 0};
      firstv = '{-1, -1};
      lastx  = '{-1, -1};
      dones  = '{0, 0};
      pheld  = '{0, 0};
      pdat   = '{8'd0, 8'd0};
      start      = 1'b1;
      start_addr = 6'(sa);
      count      = 7'(cnt);
      out_ready  = 1'b0;
      k    = 0;
      tail = -1;
      while (1) begin
         @(negedge clk);
         k++;
         if (k == 1) start = 1'b0;
         if (poke && k == 3) begin
            start      = 1'b1;
            start_addr = 6'd33;
            count      = 7'd3;
         end
         if (poke && k == 4) start = 1'b0;
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = 1'($urandom_range(0, 1));
            default: rdy = (k > hold);
         endcase
         out_ready = rdy;
         for (int d = 0; d < 2; d++) begin
            if (k == 1) chk("busy_on", d, 32'(busy_w[d]), 1);
            if (rd_en_w[d]) begin
               chk("rd_addr", d, 32'(rd_addr_w[d]),
                   32'((sa + issued[d]) % 64));
               issued[d]++;
            end
            chk("credit", d, 32'(issued[d] - deliv[d] <= 4), 1);
            if (mode == 2 && k == hold) chk("stall_reads", d, issued[d], 4);
            if (ovalid_w[d]) begin
               if (firstv[d] < 0) firstv[d] = k;
               if (pheld[d]) chk("hold_data", d, 32'(odata_w[d]),
                                 32'(pdat[d]));
               if (rdy) begin
                  chk("data", d, 32'(odata_w[d]), exp_word(sa + deliv[d]));
                  deliv[d]++;
                  lastx[d] = k;
               end
            end
            pheld[d] = ovalid_w[d] && !rdy;
            pdat[d]  = odata_w[d];
            if (done_w[d]) begin
               dones[d]++;
               chk("done_words", d, deliv[d], cnt);
               chk("done_time", d, k, lastx[d] + 1);
               chk("busy_off", d, 32'(busy_w[d]), 0);
            end
         end
         if (dones[0] > 0 && dones[1] > 0 && tail < 0) tail = k + 3;
         if (k == tail) break;
         if (k > 600) begin
            chk("timeout", 0, 0, 1);
            break;
         end
      end
      for (int d = 0; d < 2; d++) begin
         chk("done_once", d, dones[d], 1);
         chk("all_words", d, deliv[d], cnt);
         chk("all_reads", d, issued[d], cnt);
         if (mode == 0) begin
            chk("first_valid", d, firstv[d], 3 + d);
            chk("no_bubble", d, lastx[d] - firstv[d], cnt - 1);
         end
      end
      out_ready = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      start_addr = '0;
      count      = '0;
      out_ready  = 1'b0;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         chk("rst_addr", d, 32'(rd_addr_w[d]), 0);
         chk("rst_data", d, 32'(odata_w[d]), 0);
      end
      chk_idle("rst");
      rst = 1'b0;
      @(negedge clk);

      run(5, 4, 0, 0, 1'b0);
      run(62, 4, 0, 0, 1'b0);
      run(0, 64, 1, 0, 1'b0);
      run(7, 10, 2, 20, 1'b0);

      // zero-length command
      start = 1'b1;
      count = '0;
      @(negedge clk);
      start = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("zero_done", d, 32'(done_w[d]), 1);
         chk("zero_busy", d, 32'(busy_w[d]), 0);
         chk("zero_rden", d, 32'(rd_en_w[d]), 0);
      end
      repeat (4) begin
         @(negedge clk);
         chk_idle("zero_after");
      end

      run(20, 6, 0, 0, 1'b1);

      // reset in the middle of a transfer
      start      = 1'b1;
      start_addr = 6'd10;
      count      = 7'd16;
      out_ready  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         chk("mid_rst_addr", d, 32'(rd_addr_w[d]), 0);
         chk("mid_rst_data", d, 32'(odata_w[d]), 0);
      end
      chk_idle("mid_rst");
      repeat (20) begin
         @(negedge clk);
         chk_idle("post_rst");
      end
      out_ready = 1'b0;

      run(0, 2, 0, 0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_rd_streamer.md
Name: ram_rd_streamer

Overview:
- Read-side driver for the simple dual-port RAMs (ram_sdp_* family), including the init-array variants.
- On a start command, issues sequential rd_en/rd_addr requests for a block of words and tracks the RAM's fixed read latency (1 cycle unregistered, 2 cycles with registered read data).
- Returns the words as a valid/ready stream, with a small show-ahead FIFO so downstream backpressure never drops in-flight RAM data.

Parameters:
- DATA_WIDTH, 8: RAM word width.
- ADDR_WIDTH, 6: RAM address width.
- RD_LATENCY, 1: cycles from ram_rd_en to valid ram_rd_data. Legal values are 1 and 2 only; 2 matches a RAM built with registered read data.
- FIFO_DEPTH, 4: output FIFO entries. Must be >= RD_LATENCY+2; this is checked by an elaboration assertion.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  command strobe; sampled only in IDLE
- start_addr  in  ADDR_WIDTH  first address
- count  in  ADDR_WIDTH+1  number of words, 0..2^ADDR_WIDTH
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- ram_rd_en  out  1  RAM read enable
- ram_rd_addr  out  ADDR_WIDTH  RAM read address
- ram_rd_data  in  DATA_WIDTH  RAM read data
- out_valid  out  1  stream data valid
- out_ready  in  1  downstream accept
- out_data  out  DATA_WIDTH  stream data

Behaviour:
- Reset: on rst high at a clk edge, all of the following are 0 the next cycle: busy, done, ram_rd_en, ram_rd_addr, out_valid, out_data. FIFO occupancy and the latency pipeline are cleared; in-flight reads are discarded. Reset mid-transfer aborts the transfer with no done pulse.
- FSM states:
  - IDLE: start=1 with count>0 latches addr=start_addr and remaining=count, then goes to READ; busy=1 from the next cycle. start=1 with count=0 gives done=1 the next cycle, issues no reads, and stays in IDLE.
  - READ: ram_rd_en and ram_rd_addr are registered outputs. A read issues in a cycle when remaining>0 and (in_flight + fifo_count) < FIFO_DEPTH. Each issue increments addr modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-1 wraps to 0) and decrements remaining. When remaining reaches 0, go to DRAIN.
  - DRAIN: wait until in_flight=0 and the FIFO is empty, then go to IDLE with busy=0 and done=1 for exactly one cycle. done is asserted in the cycle after the last out_valid&&out_ready transfer.
- start while busy=1 is ignored.
- Latency tracking:
  - An RD_LATENCY-stage valid shift register follows each issued read.
  - ram_rd_data is written to the FIFO in the cycle the shift register's final stage is high.
  - in_flight is the number of set bits in the shift register.
- Output:
  - out_valid = FIFO not empty; out_data = FIFO head (show-ahead).
  - A transfer occurs when out_valid&&out_ready; the head pops.
  - out_data holds stable while out_valid=1 and out_ready=0.
  - Simultaneous FIFO push and pop is legal; occupancy is unchanged.
- Timing: start is sampled in cycle 0; the first ram_rd_en is in cycle 1; the first out_valid is in cycle 2+RD_LATENCY.
- Throughput: with out_ready held at 1, one word per cycle, no bubbles.
- Credit check guarantees the FIFO never overflows and no RAM data is lost under any out_ready pattern.
- Words appear in address order; no duplicates, no drops.
- count = 2^ADDR_WIDTH reads the whole RAM exactly once.

Test Plan:
- RAM model with mem[i] = (3*i) mod 256, RD_LATENCY=1, start_addr=5, count=4, out_ready=1 -> out_data 15, 18, 21, 24 on consecutive cycles. First out_valid is in cycle 3 after start. done pulses in the cycle after the 4th transfer.
- RD_LATENCY=2, start_addr=62, count=4 -> reads addresses 62, 63, 0, 1; out_data 186, 189, 0, 3; first out_valid in cycle 4.
- count=64, out_ready toggling 1,0,0,1,... randomly -> all 64 words delivered in order, no losses. ram_rd_en stalls whenever in_flight+fifo_count = FIFO_DEPTH. out_data is stable during stalls.
- out_ready=0 for 20 cycles after start with count=10 -> exactly FIFO_DEPTH reads issued, then ram_rd_en stays 0. Releasing out_ready delivers all 10 words; done then pulses once.
- count=0 start -> done=1 one cycle later, busy never asserted, ram_rd_en never asserted. A start pulse while busy -> ignored, and the original transfer completes unchanged.
- rst asserted in the middle of a count=16 transfer -> next cycle all outputs are 0 and no done pulse occurs. A new start afterwards (addr 0, count 2) -> out_data 0, 3.
